// File: rtl/lstm_gate_sequencer_if.sv
// lstm_gate_sequencer_if: config, sample, shared-MAC and result signals of the LSTM gate sequencer.
interface lstm_gate_sequencer_if #(parameter int DATA_WIDTH = 16);
    logic                  cfg_we;
    logic [1:0]            cfg_gate;
    logic [1:0]            cfg_sel;
    logic [DATA_WIDTH-1:0] cfg_data;
    logic                  cfg_err;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_x;
    logic [DATA_WIDTH-1:0] in_h;
    logic [DATA_WIDTH-1:0] mac_x;
    logic [DATA_WIDTH-1:0] mac_h;
    logic [DATA_WIDTH-1:0] mac_w0;
    logic [DATA_WIDTH-1:0] mac_w1;
    logic [DATA_WIDTH-1:0] mac_b;
    logic [1:0]            mac_gate;
    logic [DATA_WIDTH-1:0] mac_out;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_i;
    logic [DATA_WIDTH-1:0] out_f;
    logic [DATA_WIDTH-1:0] out_g;
    logic [DATA_WIDTH-1:0] out_o;
    logic                  busy;

    modport slave (
        input  cfg_we, cfg_gate, cfg_sel, cfg_data, in_valid, in_x, in_h, mac_out, out_ready,
        output cfg_err, in_ready, mac_x, mac_h, mac_w0, mac_w1, mac_b, mac_gate,
               out_valid, out_i, out_f, out_g, out_o, busy
    );

    modport master (
        output cfg_we, cfg_gate, cfg_sel, cfg_data, in_valid, in_x, in_h, mac_out, out_ready,
        input  cfg_err, in_ready, mac_x, mac_h, mac_w0, mac_w1, mac_b, mac_gate,
               out_valid, out_i, out_f, out_g, out_o, busy
    );
endinterface

// File: rtl/lstm_gate_sequencer.sv
// lstm_gate_sequencer: time-multiplexes one shared W0*x+W1*h+b unit over the four LSTM gates of a cell.
module lstm_gate_sequencer #(
    parameter int DATA_WIDTH  = 16,
    parameter int FRACT_WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    lstm_gate_sequencer_if.slave bus
);
    if (FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
        $error("FRACT_WIDTH must be smaller than DATA_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state, state_nx;
    logic [1:0]            gate_idx;
    logic [DATA_WIDTH-1:0] w0 [4];
    logic [DATA_WIDTH-1:0] w1 [4];
    logic [DATA_WIDTH-1:0] bias [4];
    logic [DATA_WIDTH-1:0] res [4];
    logic [DATA_WIDTH-1:0] x_r, h_r;
    logic                  cfg_err_r, accept, cfg_ok;

    assign bus.in_ready = (state == IDLE) || (state == DONE && bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign cfg_ok       = bus.cfg_we && state == IDLE && bus.cfg_sel != 2'd3;

    always_comb begin
        state_nx = state == IDLE ? (accept ? RUN : IDLE) :
                   state == RUN  ? (gate_idx == 2'd3 ? DONE : RUN) :
                   state == DONE ? (bus.out_ready ? (accept ? RUN : IDLE) : DONE) : IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // gate_idx parks on 3 after the last gate so the mac_* operands keep their last values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_idx  <= '0;
            x_r       <= '0;
            h_r       <= '0;
            cfg_err_r <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                w0[k]   <= '0;
                w1[k]   <= '0;
                bias[k] <= '0;
                res[k]  <= '0;
            end
        end else begin
            cfg_err_r <= bus.cfg_we && !cfg_ok;
            if (cfg_ok && bus.cfg_sel == 2'd0) w0[bus.cfg_gate]   <= bus.cfg_data;
            if (cfg_ok && bus.cfg_sel == 2'd1) w1[bus.cfg_gate]   <= bus.cfg_data;
            if (cfg_ok && bus.cfg_sel == 2'd2) bias[bus.cfg_gate] <= bus.cfg_data;
            if (accept) begin
                x_r      <= bus.in_x;
                h_r      <= bus.in_h;
                gate_idx <= '0;
            end else if (state == RUN) begin
                res[gate_idx] <= bus.mac_out;
                if (gate_idx != 2'd3) gate_idx <= gate_idx + 2'd1;
            end
        end
    end

    assign bus.cfg_err   = cfg_err_r;
    assign bus.mac_x     = x_r;
    assign bus.mac_h     = h_r;
    assign bus.mac_w0    = w0[gate_idx];
    assign bus.mac_w1    = w1[gate_idx];
    assign bus.mac_b     = bias[gate_idx];
    assign bus.mac_gate  = gate_idx;
    assign bus.out_valid = state == DONE;
    assign bus.out_i     = res[0];
    assign bus.out_f     = res[1];
    assign bus.out_g     = res[2];
    assign bus.out_o     = res[3];
    assign bus.busy      = state != IDLE;
endmodule
